sqrt: RTL and testbench



---
 rtl/cnn1d_pkg.sv | 6 +
 rtl/sqrt.sv | 94 +++++++++
 tb/tb_sqrt.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared types for the cnn1d arithmetic blocks
package cnn1d_pkg;

    typedef enum logic [1:0] {SQRT_IDLE, SQRT_BUSY, SQRT_DONE} sqrt_state_t;

endpackage

// File: rtl/sqrt.sv
// sqrt: fixed-point square root, restoring digit-by-digit, one root bit per clock
module sqrt
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  sqrt_ready_in,
    input  logic                  sqrt_valid_in,
    input  logic [DATA_WIDTH-1:0] sqrt_data_in,
    input  logic                  sqrt_ready_out,
    output logic                  sqrt_valid_out,
    output logic [DATA_WIDTH-1:0] sqrt_data_out,
    output logic                  sqrt_neg_out
);

    localparam int RAD_WIDTH = (DATA_WIDTH + FRACTION + 1) / 2 * 2;
    localparam int ITER      = RAD_WIDTH / 2;
    localparam int CW        = $clog2(ITER + 1);

    sqrt_state_t          state_q, state_d;
    logic [RAD_WIDTH-1:0] rad_q, rad_d;
    logic [ITER+1:0]      rem_q, rem_d;
    logic [ITER-1:0]      root_q, root_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;

    // One restoring step: bring down two radicand bits, try subtracting (root<<2)|1
    function automatic logic [2*ITER+1:0] step(input logic [ITER+1:0] rem,
                                               input logic [ITER-1:0] root,
                                               input logic [1:0] top);
        logic [ITER+1:0] rem_sh;
        logic [ITER+1:0] trial;
        rem_sh = (rem << 2) | {{ITER{1'b0}}, top};
        trial  = {root, 2'b01};
        return (rem_sh >= trial) ? {rem_sh - trial, (root << 1) | ITER'(1)}
                                 : {rem_sh, root << 1};
    endfunction

    assign sqrt_ready_in  = ~rst & (state_q == SQRT_IDLE);
    assign sqrt_valid_out = state_q == SQRT_DONE;
    assign sqrt_data_out  = DATA_WIDTH'(root_q);
    assign sqrt_neg_out   = neg_q;

    // Next-state and datapath update; negative operands skip straight to DONE with a zero root
    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            SQRT_IDLE: if (sqrt_valid_in && sqrt_ready_in) begin
                rad_d   = RAD_WIDTH'(sqrt_data_in) << FRACTION;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = CW'(ITER - 1);
                neg_d   = sqrt_data_in[DATA_WIDTH-1];
                state_d = sqrt_data_in[DATA_WIDTH-1] ? SQRT_DONE : SQRT_BUSY;
            end
            SQRT_BUSY: begin
                {rem_d, root_d} = step(rem_q, root_q, rad_q[RAD_WIDTH-1 -: 2]);
                rad_d   = rad_q << 2;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? SQRT_DONE : SQRT_BUSY;
            end
            SQRT_DONE: state_d = sqrt_ready_out ? SQRT_IDLE : SQRT_DONE;
            default:   state_d = SQRT_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SQRT_IDLE;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_sqrt.sv
// tb_sqrt: directed self-checking bench for the fixed-point square root
module tb_sqrt;

    logic        clk = 1'b0;
    logic        rst;
    logic        sqrt_ready_in;
    logic        sqrt_valid_in;
    logic [31:0] sqrt_data_in;
    logic        sqrt_ready_out;
    logic        sqrt_valid_out;
    logic [31:0] sqrt_data_out;
    logic        sqrt_neg_out;

    int checks = 0;
    int errors = 0;

    sqrt #(.DATA_WIDTH(32), .FRACTION(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .sqrt_ready_in  (sqrt_ready_in),
        .sqrt_valid_in  (sqrt_valid_in),
        .sqrt_data_in   (sqrt_data_in),
        .sqrt_ready_out (sqrt_ready_out),
        .sqrt_valid_out (sqrt_valid_out),
        .sqrt_data_out  (sqrt_data_out),
        .sqrt_neg_out   (sqrt_neg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic release_done(input string tag);
        sqrt_ready_out = 1'b1;
        @(posedge clk); #1;
        sqrt_ready_out = 1'b0;
        chk({tag, "_valid_after_release"}, 64'(sqrt_valid_out), 64'd0);
        chk({tag, "_ready_in_after_release"}, 64'(sqrt_ready_in), 64'd1);
        sqrt_valid_in = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; leaves the bench in DONE with the result checked
    task automatic op(input string tag, input logic [31:0] din, input logic [31:0] exp_d,
                      input logic exp_n, input int exp_lat, input bit rel);
        int n;
        chk({tag, "_ready_in"}, 64'(sqrt_ready_in), 64'd1);
        sqrt_data_in  = din;
        sqrt_valid_in = 1'b1;
        @(posedge clk); #1;
        sqrt_data_in  = $urandom;
        n = 0;
        while (!sqrt_valid_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_data"}, 64'(sqrt_data_out), 64'(exp_d));
        chk({tag, "_neg"}, 64'(sqrt_neg_out), 64'(exp_n));
        if (rel) release_done(tag);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] big;
        int stray;
        rst = 1'b1;
        sqrt_valid_in  = 1'b0;
        sqrt_data_in   = '0;
        sqrt_ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready_in", 64'(sqrt_ready_in), 64'd0);
        chk("reset_valid", 64'(sqrt_valid_out), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready_in", 64'(sqrt_ready_in), 64'd1);
        chk("post_reset_data", 64'(sqrt_data_out), 64'd0);
        chk("post_reset_neg", 64'(sqrt_neg_out), 64'd0);
        @(posedge clk); #1;

        op("four", 32'h0400_0000, 32'h0200_0000, 1'b0, 28, 1'b1);
        op("two", 32'h0200_0000, 32'h016A_09E6, 1'b0, 28, 1'b1);
        op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 28, 1'b1);
        op("lsb", 32'h0000_0001, 32'h0000_1000, 1'b0, 28, 1'b1);
        op("max", 32'h7FFF_FFFF, 32'h0B50_4F33, 1'b0, 28, 1'b0);
        r   = 64'(sqrt_data_out);
        big = 64'h7FFF_FFFF << 24;
        chk("max_floor_low", 64'(r * r <= big), 64'd1);
        chk("max_floor_high", 64'((r + 1) * (r + 1) > big), 64'd1);
        release_done("max");
        op("neg", 32'hFF00_0000, 32'h0000_0000, 1'b1, 0, 1'b1);
        op("one", 32'h0100_0000, 32'h0100_0000, 1'b0, 28, 1'b1);

        op("quarter", 32'h0040_0000, 32'h0080_0000, 1'b0, 28, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(sqrt_valid_out), 64'd1);
            chk("hold_data", 64'(sqrt_data_out), 64'h0080_0000);
            chk("hold_ready_in", 64'(sqrt_ready_in), 64'd0);
        end
        release_done("quarter");

        sqrt_data_in  = 32'h0400_0000;
        sqrt_valid_in = 1'b1;
        @(posedge clk); #1;
        sqrt_valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_ready_in", 64'(sqrt_ready_in), 64'd0);
        rst = 1'b0;
        #1;
        chk("midreset_ready_after", 64'(sqrt_ready_in), 64'd1);
        chk("midreset_valid", 64'(sqrt_valid_out), 64'd0);
        chk("midreset_data", 64'(sqrt_data_out), 64'd0);
        chk("midreset_neg", 64'(sqrt_neg_out), 64'd0);
        stray = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (sqrt_valid_out) stray++;
        end
        chk("midreset_no_stale_valid", 64'(stray), 64'd0);
        op("nine", 32'h0900_0000, 32'h0300_0000, 1'b0, 28, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
